// File: rtl/rx_pkg.sv
// Shared receive-path types and frame geometry constants.
// Used by the PHY back end, frame sync and framing layer.
package rx_pkg;

    typedef logic [1:0] qpsk_sym_t;

    typedef enum logic [1:0] {
        SEARCH,
        VERIFY,
        LOCKED
    } sync_state_t;

    localparam int SOF_LEN_C     = 25;
    localparam int PAYLOAD_LEN_C = 63;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/fsc_stats.sv
// Saturating lock-loss and delivered-frame counters for frame sync.
// Only instantiated when FRAME_SYNC_STATS_EN is defined.
module fsc_stats
    import rx_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        loss_evt,
    input  logic        frame_evt,
    output logic [15:0] lock_loss_cnt,
    output logic [15:0] frame_cnt
);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lock_loss_cnt <= '0;
            frame_cnt     <= '0;
        end else begin
            if (loss_evt)
                lock_loss_cnt <= sat_inc16(lock_loss_cnt);
            if (frame_evt)
                frame_cnt <= sat_inc16(frame_cnt);
        end
    end

endmodule

// File: rtl/frame_sync_controller.sv
// Frame acquisition/tracking FSM with flywheel; forwards payload symbols.
// Stats counters are built only when FRAME_SYNC_STATS_EN is defined.
module frame_sync_controller
    import rx_pkg::*;
#(
    parameter int PAYLOAD_LEN = PAYLOAD_LEN_C,
    parameter int SOF_LEN     = SOF_LEN_C,
    parameter int TOL         = 2,
    parameter int VERIFY_N    = 2,
    parameter int MISS_MAX    = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        sym_valid,
    input  qpsk_sym_t   sym_data,
    input  logic        sof_det,
    output logic        out_valid,
    output qpsk_sym_t   out_data,
    output logic        out_first,
    output logic        out_last,
    output logic        locked,
    output logic [15:0] lock_loss_cnt,
    output logic [15:0] frame_cnt
);

    localparam int FRAME_SYMS = PAYLOAD_LEN + SOF_LEN;
    localparam int PW = $clog2(FRAME_SYMS + TOL + 2);
    localparam int CW = $clog2(VERIFY_N + 1);
    localparam int MW = $clog2(MISS_MAX + 1);

    localparam logic [PW-1:0] WIN_LO   = PW'(FRAME_SYMS - TOL);
    localparam logic [PW-1:0] POS_HI   = PW'(FRAME_SYMS + TOL);
    localparam logic [PW-1:0] POS_WRAP = PW'(TOL + 1);
    localparam logic [PW-1:0] PAY_N    = PW'(PAYLOAD_LEN);
    localparam logic [PW-1:0] PAY_LAST = PW'(PAYLOAD_LEN - 1);
    localparam logic [CW-1:0] CONF_END = CW'(VERIFY_N - 1);
    localparam logic [MW-1:0] MISS_END = MW'(MISS_MAX - 1);

    sync_state_t   state;
    logic [PW-1:0] pos;
    logic [CW-1:0] confirm;
    logic [MW-1:0] miss;

    logic in_win;
    logic fwd;
    logic fly;

    assign in_win = (pos >= WIN_LO) && (pos <= POS_HI);
    assign fwd    = (state == LOCKED) && sym_valid && !sof_det
                    && (pos < PAY_N);
    assign fly    = (state == LOCKED) && sym_valid && !sof_det
                    && (pos == POS_HI);
    assign locked = (state == LOCKED);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= SEARCH;
            pos       <= '0;
            confirm   <= '0;
            miss      <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_first <= 1'b0;
            out_last  <= 1'b0;
        end else begin
            out_valid <= fwd;
            out_data  <= sym_data;
            out_first <= fwd && (pos == '0);
            out_last  <= fwd && (pos == PAY_LAST);

            unique case (state)
                SEARCH: begin
                    if (sof_det) begin
                        state   <= VERIFY;
                        pos     <= '0;
                        confirm <= '0;
                    end
                end
                VERIFY: begin
                    if (sof_det) begin
                        pos <= '0;
                        if (!in_win) begin
                            confirm <= '0;
                        end else if (confirm == CONF_END) begin
                            state   <= LOCKED;
                            confirm <= '0;
                            miss    <= '0;
                        end else begin
                            confirm <= confirm + 1'b1;
                        end
                    end else if (sym_valid) begin
                        if (pos == POS_HI) begin
                            state <= SEARCH;
                            pos   <= '0;
                        end else begin
                            pos <= pos + 1'b1;
                        end
                    end
                end
                LOCKED: begin
                    // An out-of-window SOF is a false correlation: the
                    // beat still advances pos like any other symbol.
                    if (sof_det && in_win) begin
                        pos  <= '0;
                        miss <= '0;
                    end else if (fly) begin
                        if (miss == MISS_END) begin
                            state <= SEARCH;
                            pos   <= '0;
                            miss  <= '0;
                        end else begin
                            pos  <= POS_WRAP;
                            miss <= miss + 1'b1;
                        end
                    end else if (sym_valid) begin
                        pos <= pos + 1'b1;
                    end
                end
                default: state <= SEARCH;
            endcase
        end
    end

`ifdef FRAME_SYNC_STATS_EN
    logic loss_evt;
    logic frame_evt;

    assign loss_evt  = fly && (miss == MISS_END);
    assign frame_evt = fwd && (pos == PAY_LAST);

    fsc_stats u_stats (
        .clk           (clk),
        .rst_n         (rst_n),
        .loss_evt      (loss_evt),
        .frame_evt     (frame_evt),
        .lock_loss_cnt (lock_loss_cnt),
        .frame_cnt     (frame_cnt)
    );
`else
    assign lock_loss_cnt = '0;
    assign frame_cnt     = '0;
`endif

endmodule
